// File: rtl/circuit2_sched_pkg.sv
// Shared definitions for the circuit2_sched block.
//   DATAWIDTH_DEF : default operand/result width
//   state_t       : sequencing FSM states, in execution order
package circuit2_sched_pkg;

  localparam int unsigned DATAWIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_D   = 3'd1,
    S_E   = 3'd2,
    S_F   = 3'd3,
    S_CMP = 3'd4,
    S_OUT = 3'd5
  } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor, wraps modulo 2^DATAWIDTH.
//   a, b : operands
//   sub  : 1 = a - b, 0 = a + b
//   y    : result
module alu_addsub
  import circuit2_sched_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sub,
  output logic [DATAWIDTH-1:0] y
);

  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/circuit2_sched.sv
// Multi-cycle scheduled datapath:
//   d=a+b, e=a+c, f=a-b; g=(d<e)?e:d; h=(d==e)?f:g;
//   x=g<<(d<e), z=h>>>(d==e)  (signed compare, arithmetic right shift)
// One shared add/sub unit and one shared comparator, six-cycle operation.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   start   : request, sampled only in IDLE
//   a, b, c : signed operands
//   busy    : FSM not in IDLE
//   done    : one-cycle pulse after x/z update
//   x, z    : registered signed results
module circuit2_sched
  import circuit2_sched_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z
);

  state_t state, state_nxt;

  logic [DATAWIDTH-1:0] ra, rb, rc;
  logic [DATAWIDTH-1:0] d, e, f, g;
  logic                 dlte, deqe;

  logic [DATAWIDTH-1:0] alu_b;
  logic                 alu_sub;
  logic [DATAWIDTH-1:0] alu_y;

  logic                 cmp_lt, cmp_eq;
  logic [DATAWIDTH-1:0] h, x_nxt, z_nxt;

  // Operand steering for the shared add/sub: S_D a+b, S_E a+c, S_F a-b.
  always_comb begin
    alu_b   = (state == S_E) ? rc : rb;
    alu_sub = (state == S_F);
  end

  alu_addsub #(
    .DATAWIDTH (DATAWIDTH)
  ) u_alu (
    .a   (ra),
    .b   (alu_b),
    .sub (alu_sub),
    .y   (alu_y)
  );

  // Shared signed comparator, only consumed in S_CMP.
  always_comb begin
    cmp_lt = $signed(d) < $signed(e);
    cmp_eq = (d == e);
  end

  // Output-stage muxes and shifters, consumed in S_OUT from registered flags.
  always_comb begin
    h     = deqe ? f : g;
    x_nxt = g << dlte;
    z_nxt = $unsigned($signed(h) >>> deqe);
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    state_nxt = start ? S_D : IDLE;
      S_D:     state_nxt = S_E;
      S_E:     state_nxt = S_F;
      S_F:     state_nxt = S_CMP;
      S_CMP:   state_nxt = S_OUT;
      S_OUT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra   <= '0;
      rb   <= '0;
      rc   <= '0;
      d    <= '0;
      e    <= '0;
      f    <= '0;
      g    <= '0;
      dlte <= 1'b0;
      deqe <= 1'b0;
      x    <= '0;
      z    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ra <= a;
            rb <= b;
            rc <= c;
          end
        end
        S_D:   d <= alu_y;
        S_E:   e <= alu_y;
        S_F:   f <= alu_y;
        S_CMP: begin
          dlte <= cmp_lt;
          deqe <= cmp_eq;
          g    <= cmp_lt ? e : d;
        end
        S_OUT: begin
          x    <= x_nxt;
          z    <= z_nxt;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit2_sched.sv
module tb_circuit2_sched;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, c;
  logic         busy, done;
  logic [W-1:0] x, z;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] z;
    int           scyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   ndone  = 0;
  int   passed = 0;
  int   total  = 0;
  logic [W-1:0] last_x, last_z;

  circuit2_sched #(
    .DATAWIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .x     (x),
    .z     (z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // Reference model written directly from the equations.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [W-1:0] ic, input int scyc);
    logic signed [W-1:0] md, me, mf, mg, mh;
    logic lt, eq;
    exp_t r;
    md = ia + ib;
    me = ia + ic;
    mf = ia - ib;
    lt = (md < me);
    eq = (md == me);
    mg = lt ? me : md;
    mh = eq ? mf : mg;
    r.x    = lt ? {mg[W-2:0], 1'b0} : mg;
    r.z    = eq ? {mh[W-1], mh[W-1:1]} : mh;
    r.scyc = scyc;
    return r;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      ndone++;
      if (q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t ex;
        ex = q.pop_front();
        check("x", {32'd0, x}, {32'd0, ex.x});
        check("z", {32'd0, z}, {32'd0, ex.z});
        check("latency", 64'(cyc - ex.scyc), 64'd5);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        last_x = ex.x;
        last_z = ex.z;
      end
    end
  end

  task automatic wait_done(input int target);
    for (int i = 0; i < 20 && ndone < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_timeout", {63'd0, (ndone >= target)}, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic);
    int tgt;
    tgt = ndone + 1;
    @(negedge clk);
    a = ia; b = ib; c = ic; start = 1'b1;
    q.push_back(model(ia, ib, ic, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; c = $urandom;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(tgt);
  endtask

  initial begin
    int saved;
    int tgt;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
    last_x = '0; last_z = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", {32'd0, x}, 64'd0);
    check("rst_z", {32'd0, z}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(32'd5, 32'd3, 32'd1);
    run_op(32'd1, 32'd2, 32'd3);
    run_op(32'd10, 32'd4, 32'd4);
    run_op(32'hFFFF_FFF8, 32'd0, 32'd0);
    run_op(32'h7FFF_FFFF, 32'd1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, $urandom);
    end

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_x", {32'd0, x}, {32'd0, last_x});
    check("hold_z", {32'd0, z}, {32'd0, last_z});

    // Start held high, operands changed mid-operation; second op begins in done cycle.
    tgt = ndone + 1;
    @(negedge clk);
    a = 32'd1; b = 32'd2; c = 32'd3; start = 1'b1;
    q.push_back(model(32'd1, 32'd2, 32'd3, cyc + 1));
    @(posedge clk);
    #1;
    a = 32'd10; b = 32'd4; c = 32'd4;
    q.push_back(model(32'd10, 32'd4, 32'd4, cyc + 6));
    wait_done(tgt);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '0; b = '0; c = '0;
    wait_done(tgt + 1);
    repeat (8) @(negedge clk);
    check("no_extra_op", 64'(ndone), 64'(tgt + 1));

    // Reset asserted while in S_F aborts the operation.
    @(negedge clk);
    a = 32'd5; b = 32'd3; c = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    saved = ndone;
    rst = 1'b0;
    #1;
    check("abort_x", {32'd0, x}, 64'd0);
    check("abort_z", {32'd0, z}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("no_done_after_abort", 64'(ndone), 64'(saved));

    // Start on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tgt = ndone + 1;
    a = 32'h7FFF_FFFF; b = 32'd1; c = 32'd0; start = 1'b1;
    q.push_back(model(32'h7FFF_FFFF, 32'd1, 32'd0, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_release_start", {63'd0, busy}, 64'd1);
    wait_done(tgt);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/circuit2_sched.md
CIRCUIT2_SCHED -- requirements
Module: circuit2_sched

Interface
REQ-001 Parameter: DATAWIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset.
REQ-004 start  input  1  request to compute on the current a, b, c; sampled only in IDLE.
REQ-005 a, b, c  input  DATAWIDTH each  signed two's-complement operands.
REQ-006 busy  output  1  high whenever the FSM is not in IDLE.
REQ-007 done  output  1  one-cycle pulse when x and z have been updated.
REQ-008 x, z  output  DATAWIDTH each  signed results, registered, held between completions.

Function
REQ-009 The block SHALL compute with one shared add/sub unit and one shared signed comparator, sequenced over multiple cycles:
- d=a+b, e=a+c, f=a-b
- dLTe=(d<e), dEQe=(d==e)
- g=dLTe?e:d, h=dEQe?f:g
- x=g<<dLTe, z=h>>>dEQe
REQ-010 All add/sub results SHALL wrap modulo 2^DATAWIDTH; comparisons SHALL be signed; >>> SHALL be arithmetic (sign-filling); << SHALL zero-fill and discard the MSB.
REQ-011 FSM states SHALL be IDLE, S_D, S_E, S_F, S_CMP, S_OUT; every non-IDLE state SHALL advance unconditionally to the next in that order, and S_OUT SHALL go to IDLE.
REQ-012 In IDLE with start=1, the rising edge SHALL latch a, b, c into internal registers and enter S_D; in IDLE with start=0 the FSM SHALL stay in IDLE.
REQ-013 Register writes per state: S_D writes d; S_E writes e; S_F writes f; S_CMP writes dLTe, dEQe, g; S_OUT writes x and z.
REQ-014 Latency: with start sampled at edge k, x and z SHALL update at edge k+5, done SHALL be 1 for exactly the cycle following edge k+5, and busy SHALL be 1 from edge k+1 through edge k+5.
REQ-015 start while busy=1 SHALL be ignored, with no queuing; input changes after edge k SHALL NOT affect the result.
REQ-016 The cycle in which done=1 is an IDLE cycle: start=1 in that cycle SHALL be accepted, giving back-to-back operations of 6 cycles each.
REQ-017 x and z SHALL change only at the S_OUT edge or on reset.

Reset
REQ-018 While rst=0, the FSM SHALL be IDLE, busy=0, done=0, x=0, z=0, and all internal registers (operands, d, e, f, g, flags) SHALL be 0, asynchronously.
REQ-019 Assertion of rst mid-operation SHALL abort the operation; after release the block SHALL be in IDLE and SHALL NOT emit done for the aborted request.
REQ-020 The first rising edge after rst deasserts SHALL be able to accept start.

Structure
REQ-021 A shared package SHALL hold the FSM state enum and the DATAWIDTH default constant.
REQ-022 The shared add/sub unit SHALL be a sub-module named alu_addsub, with ports a, b, sub (1 = subtract) and y, parameterised by DATAWIDTH.
REQ-023 The comparator, muxes and shifters SHALL be inline logic in circuit2_sched.

Verification
REQ-024 a=5, b=3, c=1 -> d=8, e=6, no flags; x=8, z=8; done exactly 5 edges after start.
REQ-025 a=1, b=2, c=3 -> dLTe=1, g=4; x=8, z=4.
REQ-026 a=10, b=4, c=4 -> dEQe=1, h=f=6; x=14, z=3. Same test with a=-8, b=0, c=0 -> z=0xFFFFFFFC.
REQ-027 a=0x7FFFFFFF, b=1, c=0 -> d wraps to 0x80000000, dLTe=1; x=0xFFFFFFFE, z=0x7FFFFFFF.
REQ-028 start held high with the operands changed mid-operation -> the first result is unaffected; the second operation starts in the done cycle and completes 6 cycles later.
REQ-029 rst=0 asserted in S_F -> x=0, z=0, busy=0 immediately; no done pulse follows; the next start completes correctly.
